seq_detect_moore_param: RTL

- Parametrised Moore sequence detector, next generation of the fixed 1001 overlapping detector in the fsm library.
- Matches any N-bit serial pattern given by parameter.
- Overlapping or non-overlapping mode is selected by parameter.
- Adds a sample enable, a saturating match counter and a synchronous counter clear.
- Sits on a 1-bit serial stream inside fsm-style control logic. Used standalone or ahead of framing/sync logic.

---
 rtl/seq_detect_moore_param.sv | 98 +++++++++
 1 files changed

// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore serial pattern detector with a sample enable, a saturating
// match counter and a synchronous counter clear.
module seq_detect_moore_param #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1001,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in,
  input  logic                     clr,
  output logic                     d,
  output logic [$clog2(N+1)-1:0]   state,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int SW   = $clog2(N + 1);
  localparam int TABN = 2 ** SW;

  // Next matched-prefix length after consuming b from prefix length k: the
  // longest prefix of PATTERN that is a suffix of (matched prefix, b).
  function automatic logic [SW-1:0] next_state(input int k, input logic b);
    logic [16:0] s;
    int          best;
    logic        ok;
    s    = '0;
    best = 0;
    if (k == N && !OVERLAP) begin
      best = (b == PATTERN[N-1]) ? 1 : 0;
    end else begin
      // s[0] is the newest bit, s[i] the bit consumed i edges earlier
      s[0] = b;
      for (int i = 1; i <= 16; i++) begin
        if (i <= k) s[i] = PATTERN[N-k+i-1];
      end
      for (int j = 1; j <= N; j++) begin
        if (j <= k + 1) begin
          ok = 1'b1;
          for (int t = 0; t < N; t++) begin
            if (t < j && s[t] != PATTERN[N-j+t]) ok = 1'b0;
          end
          if (ok) best = j;
        end
      end
    end
    return SW'(best);
  endfunction

  logic [SW-1:0] nxt0 [TABN];
  logic [SW-1:0] nxt1 [TABN];

  // Unreachable encodings above N fall back to the idle state.
  generate
    for (genvar gi = 0; gi < TABN; gi++) begin : g_tab
      if (gi <= N) begin : g_live
        assign nxt0[gi] = next_state(gi, 1'b0);
        assign nxt1[gi] = next_state(gi, 1'b1);
      end else begin : g_dead
        assign nxt0[gi] = '0;
        assign nxt1[gi] = '0;
      end
    end
  endgenerate

  logic [SW-1:0]    state_q, state_d;
  logic             d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en) begin
      state_d = in ? nxt1[state_q] : nxt0[state_q];
      if (state_d == SW'(N) && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
    if (clr) cnt_d = '0;
    d_d = (state_d == SW'(N));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      d_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d         = d_q;
  assign state     = state_q;
  assign match_cnt = cnt_q;

endmodule
